ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifu_pkg.sv | 18 +
 rtl/ifu_fifo.sv | 60 ++++++
 rtl/ifetch_unit.sv | 121 ++++++++++++
 tb/tb_ifetch_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The optional misaligned-fetch trap is enabled by defining IFU_MISALIGN_TRAP_EN.
package ifu_pkg;

  localparam int unsigned INSN_BYTES = 4;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_TRAP  = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch buffer: power-of-two deep FIFO of {inst, pc} entries with flush.
// Flush wins over push/pop; asynchronous reset empties it immediately.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_flush,
  input  logic       i_push,
  input  ifu_entry_t i_wdata,
  input  logic       i_pop,
  output ifu_entry_t o_rdata,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  ifu_entry_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign o_full  = (count_q == FULL_CNT);
  assign o_empty = (count_q == '0);
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);
  assign o_rdata = mem_q[rd_ptr_q];

  // Pointers are exactly AW bits wide, so increments wrap modulo DEPTH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_flush && do_push) mem_q[wr_ptr_q] <= i_wdata;
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: BOOT/FETCH/TRAP sequencer feeding a prefetch buffer.
// Define IFU_MISALIGN_TRAP_EN to trap on fetch addresses with pc[1:0] != 0.
module ifetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] o_imem_addr,
  output logic        o_imem_req,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic        o_trap,
  output logic [31:0] o_trap_pc,
  output ifu_state_e  o_dbg_state
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  ifu_entry_t  head;
  ifu_entry_t  hold_q;
  ifu_entry_t  wdata;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic        push;
  logic        misaligned;

  // Handshake: an entry moves on a rising edge where o_inst_valid && i_inst_ready,
  // unless i_redirect is high (redirect discards the buffer instead).
  assign o_inst_valid = !fifo_empty;
  assign pop          = o_inst_valid && i_inst_ready && !i_redirect;

`ifdef IFU_MISALIGN_TRAP_EN
  assign misaligned = (pc_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign push        = (state_q == ST_FETCH) && !misaligned && !i_redirect
                       && (!fifo_full || pop);
  assign o_imem_req  = push;
  assign o_imem_addr = pc_q;
  assign o_dbg_state = state_q;
  assign wdata       = '{inst: i_imem_rdata, pc: pc_q};

  ifu_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_redirect),
    .i_push  (push),
    .i_wdata (wdata),
    .i_pop   (pop),
    .o_rdata (head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (i_redirect) begin
      state_d = ST_FETCH;
      pc_d    = i_redirect_pc;
    end else begin
      case (state_q)
        ST_BOOT:  state_d = ST_FETCH;
        ST_FETCH: begin
          if (misaligned)  state_d = ST_TRAP;
          else if (push)   pc_d    = pc_q + INSN_BYTES;
        end
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Remember the last head shown so outputs stay stable while the buffer is empty.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)         hold_q <= '0;
    else if (!fifo_empty) hold_q <= head;
  end

  assign o_inst    = fifo_empty ? hold_q.inst : head.inst;
  assign o_inst_pc = fifo_empty ? hold_q.pc   : head.pc;

`ifdef IFU_MISALIGN_TRAP_EN
  logic [31:0] trap_pc_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                               trap_pc_q <= '0;
    else if (i_redirect)                        trap_pc_q <= '0;
    else if (state_q == ST_FETCH && misaligned) trap_pc_q <= pc_q;
  end

  assign o_trap    = (state_q == ST_TRAP);
  assign o_trap_pc = trap_pc_q;
`else
  assign o_trap    = 1'b0;
  assign o_trap_pc = '0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a scoreboard of expected fetch PCs.
// Follows IFU_MISALIGN_TRAP_EN to pick the trap or no-trap expectations.
module tb_ifetch_unit;
  import ifu_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  // ---------------- clock / reset ----------------
  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] o_imem_addr;
  logic        o_imem_req;
  logic [31:0] i_imem_rdata;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        o_inst_valid;
  logic        i_inst_ready;
  logic        o_trap;
  logic [31:0] o_trap_pc;
  ifu_state_e  dbg_state;

  always #5 i_clk = ~i_clk;

  ifetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .o_imem_addr   (o_imem_addr),
    .o_imem_req    (o_imem_req),
    .i_imem_rdata  (i_imem_rdata),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_inst        (o_inst),
    .o_inst_pc     (o_inst_pc),
    .o_inst_valid  (o_inst_valid),
    .i_inst_ready  (i_inst_ready),
    .o_trap        (o_trap),
    .o_trap_pc     (o_trap_pc),
    .o_dbg_state   (dbg_state)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[15:0], 16'h0013};
  endfunction

  assign i_imem_rdata = mem_word(o_imem_addr);

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          n_tests    = 0;
  int          n_fail     = 0;
  int          sb_checks  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_stream(input logic [31:0] start);
    logic [31:0] pc;
    pc = start;
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(pc);
      pc = pc + 32'd4;
    end
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n && o_inst_valid && i_inst_ready && !i_redirect) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL sb_underflow observed_pc=%h expected=none", o_inst_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", o_inst_pc, e);
        chk("sb_inst", o_inst, mem_word(e));
        sb_checks++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_redirect(input logic [31:0] tgt, input logic rdy, input bit expect_fetch);
    @(posedge i_clk);
    #1;
    i_redirect    = 1'b1;
    i_redirect_pc = tgt;
    i_inst_ready  = rdy;
    exp_q.delete();
    if (expect_fetch) load_stream(tgt);
    @(posedge i_clk);
    #1;
    i_redirect = 1'b0;
  endtask

  initial begin
    #200000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    i_rst_n       = 1'b0;
    i_redirect    = 1'b0;
    i_redirect_pc = '0;
    i_inst_ready  = 1'b1;
    load_stream(RESET_PC);
    #12;
    chk("rst_valid",   32'(o_inst_valid), 32'd0);
    chk("rst_req",     32'(o_imem_req),   32'd0);
    chk("rst_trap",    32'(o_trap),       32'd0);
    chk("rst_trap_pc", o_trap_pc,         32'd0);
    chk("rst_inst",    o_inst,            32'd0);
    chk("rst_inst_pc", o_inst_pc,         32'd0);
    chk("rst_addr",    o_imem_addr,       RESET_PC);
    chk("rst_state",   32'(dbg_state),    32'(ST_BOOT));

    // Boot cycle, then first fetch, then first instruction one cycle later.
    @(posedge i_clk); #1; i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("boot_req",   32'(o_imem_req), 32'd0);
    chk("boot_state", 32'(dbg_state),  32'(ST_BOOT));
    @(negedge i_clk);
    chk("f0_req",   32'(o_imem_req),   32'd1);
    chk("f0_addr",  o_imem_addr,       32'd0);
    chk("f0_valid", 32'(o_inst_valid), 32'd0);
    @(negedge i_clk);
    chk("i0_valid", 32'(o_inst_valid), 32'd1);
    chk("i0_inst",  o_inst,            32'h0000_0013);
    chk("i0_pc",    o_inst_pc,         32'd0);
    repeat (4) @(negedge i_clk);

    // Stalled consumer: buffer fills with PC 0 and 4, fetch stops at 8.
    do_redirect(32'h0, 1'b0, 1'b1);
    repeat (5) @(posedge i_clk);
    @(negedge i_clk);
    chk("full_req",   32'(o_imem_req),   32'd0);
    chk("full_addr",  o_imem_addr,       32'd8);
    chk("full_valid", 32'(o_inst_valid), 32'd1);
    chk("full_pc",    o_inst_pc,         32'd0);
    @(posedge i_clk); #1; i_inst_ready = 1'b1;
    @(negedge i_clk);
    chk("fullpop_req", 32'(o_imem_req), 32'd1);
    @(negedge i_clk);
    chk("fullpop_valid", 32'(o_inst_valid), 32'd1);

    // Redirect while full.
    do_redirect(32'h100, 1'b1, 1'b1);
    @(negedge i_clk);
    chk("rd_valid",   32'(o_inst_valid), 32'd0);
    chk("rd_addr",    o_imem_addr,       32'h100);
    chk("rd_req",     32'(o_imem_req),   32'd1);
    chk("rd_hold_pc", o_inst_pc,         32'd8);
    chk("rd_hold_in", o_inst,            mem_word(32'd8));
    @(negedge i_clk);
    chk("rd_pc", o_inst_pc, 32'h100);
    repeat (3) @(negedge i_clk);

    // PC wrap at the top of the address space.
    do_redirect(32'hFFFF_FFFC, 1'b1, 1'b1);
    @(negedge i_clk);
    chk("wrap_addr", o_imem_addr, 32'hFFFF_FFFC);
    @(negedge i_clk);
    chk("wrap_pc0",  o_inst_pc,   32'hFFFF_FFFC);
    chk("wrap_trap", 32'(o_trap), 32'd0);
    @(negedge i_clk);
    chk("wrap_pc1",   o_inst_pc,         32'h0);
    chk("wrap_valid", 32'(o_inst_valid), 32'd1);
    @(negedge i_clk);
    chk("wrap_pc2", o_inst_pc, 32'h4);

    // Asynchronous reset with two entries buffered.
    do_redirect(32'h300, 1'b0, 1'b1);
    repeat (4) @(posedge i_clk);
    @(negedge i_clk);
    chk("pre_rst_valid", 32'(o_inst_valid), 32'd1);
    chk("pre_rst_pc",    o_inst_pc,         32'h300);
    chk("pre_rst_req",   32'(o_imem_req),   32'd0);
    @(posedge i_clk); #3;
    i_rst_n = 1'b0;
    exp_q.delete();
    load_stream(RESET_PC);
    #1;
    chk("arst_valid", 32'(o_inst_valid), 32'd0);
    chk("arst_req",   32'(o_imem_req),   32'd0);
    chk("arst_pc",    o_inst_pc,         32'd0);
    chk("arst_state", 32'(dbg_state),    32'(ST_BOOT));
    @(posedge i_clk); #1;
    i_rst_n      = 1'b1;
    i_inst_ready = 1'b1;
    @(negedge i_clk);
    chk("rb_req", 32'(o_imem_req), 32'd0);
    @(negedge i_clk);
    chk("rb_addr", o_imem_addr,     RESET_PC);
    chk("rb_req1", 32'(o_imem_req), 32'd1);
    @(negedge i_clk);
    chk("rb_valid", 32'(o_inst_valid), 32'd1);
    chk("rb_pc",    o_inst_pc,         RESET_PC);
    repeat (2) @(negedge i_clk);

`ifdef IFU_MISALIGN_TRAP_EN
    do_redirect(32'h102, 1'b1, 1'b0);
    @(negedge i_clk);
    chk("mis_req",  32'(o_imem_req), 32'd0);
    chk("mis_trap", 32'(o_trap),     32'd0);
    @(negedge i_clk);
    chk("trap_o",     32'(o_trap),       32'd1);
    chk("trap_pc",    o_trap_pc,         32'h102);
    chk("trap_req",   32'(o_imem_req),   32'd0);
    chk("trap_valid", 32'(o_inst_valid), 32'd0);
    chk("trap_state", 32'(dbg_state),    32'(ST_TRAP));
    @(negedge i_clk);
    chk("trap_stay", 32'(o_trap), 32'd1);
    do_redirect(32'h200, 1'b1, 1'b1);
    @(negedge i_clk);
    chk("untrap_o",    32'(o_trap),     32'd0);
    chk("untrap_addr", o_imem_addr,     32'h200);
    chk("untrap_req",  32'(o_imem_req), 32'd1);
    @(negedge i_clk);
    chk("untrap_pc", o_inst_pc, 32'h200);
`else
    do_redirect(32'h102, 1'b1, 1'b1);
    @(negedge i_clk);
    chk("mis_req",  32'(o_imem_req), 32'd1);
    chk("mis_addr", o_imem_addr,     32'h102);
    chk("mis_trap", 32'(o_trap),     32'd0);
    @(negedge i_clk);
    chk("mis_pc",      o_inst_pc,      32'h102);
    chk("mis_trap_pc", o_trap_pc,      32'd0);
    chk("mis_state",   32'(dbg_state), 32'(ST_FETCH));
`endif
    repeat (3) @(negedge i_clk);

    chk("sb_active", 32'(sb_checks >= 10), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
